fetch_sequencer: RTL and testbench

- Instruction-fetch and next-PC stage directly upstream of the execute stage.
- Holds the PC, fetches instruction words over a variable-latency ready/ack instruction-memory port, and presents the held instruction fields and PC+4 to decode/execute.
- Selects the next PC from the execute stage's branch word-address and Zero flag, the jump fields, or the jr register value, and commits it once per instruction.

---
 rtl/fetch_sequencer_if.sv | 9 +
 rtl/fetch_sequencer.sv | 74 +++++++
 tb/tb_fetch_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory request/ack port between the fetch stage and memory.
interface fetch_sequencer_if #(parameter int AW = 14);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC holder, variable-latency instruction fetch and next-PC selection,
// committing one instruction per EXEC cycle that is not stalled.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic                      clock,
    input  logic                      reset,
    fetch_sequencer_if.master         imem,
    output logic [31:0]               Instruction,
    output logic [31:0]               PC_plus_4,
    output logic                      inst_valid,
    input  logic                      stall,
    input  logic                      Branch,
    input  logic                      nBranch,
    input  logic                      Jmp,
    input  logic                      Jal,
    input  logic                      Jr,
    input  logic                      Zero,
    input  logic [31:0]               Addr_Result,
    input  logic [31:0]               Read_data_1,
    output logic                      commit,
    output logic                      pc_misalign,
    output logic [31:0]               retired_count
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        taken;
    logic        unused_addr_hi;
    assign unused_addr_hi = &{1'b0, Addr_Result[31:30]};
    assign PC_plus_4 = pc + 32'd4;
    assign imem.imem_addr = pc[IMEM_AW+1:2];
    assign commit = inst_valid & ~stall;
    assign taken = (Branch & Zero) | (nBranch & ~Zero);
    // Jr outranks jumps, jumps outrank conditional branches
    assign next_pc = Jr ? {Read_data_1[31:2], 2'b00} :
                     (Jmp | Jal) ? {PC_plus_4[31:28], Instruction[25:0], 2'b00} :
                     taken ? {Addr_Result[29:0], 2'b00} : PC_plus_4;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            Instruction   <= 32'd0;
            imem.imem_req <= 1'b0;
            inst_valid    <= 1'b0;
            pc_misalign   <= 1'b0;
            retired_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= FETCH;
                    imem.imem_req <= 1'b1;
                end
                FETCH: if (imem.imem_ack) begin
                    Instruction   <= imem.imem_rdata;
                    imem.imem_req <= 1'b0;
                    inst_valid    <= 1'b1;
                    state         <= EXEC;
                end
                EXEC: if (!stall) begin
                    pc            <= next_pc;
                    retired_count <= retired_count + 32'd1;
                    pc_misalign   <= pc_misalign | (Jr & (|Read_data_1[1:0]));
                    inst_valid    <= 1'b0;
                    imem.imem_req <= 1'b1;
                    state         <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed fetch/execute scenarios checked against a behavioural
// model every cycle, plus literal expectations for the key scenario results.
module tb_fetch_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instruction, PC_plus_4, Addr_Result, Read_data_1, retired_count;
    logic        inst_valid, stall, Branch, nBranch, Jmp, Jal, Jr, Zero, commit, pc_misalign;
    int          checks = 0;
    int          failures = 0;
    fetch_sequencer_if #(.AW(14)) bus ();
    fetch_sequencer #(.RESET_PC(32'h0), .IMEM_AW(14)) dut (
        .clock(clock), .reset(reset), .imem(bus.master),
        .Instruction(Instruction), .PC_plus_4(PC_plus_4), .inst_valid(inst_valid),
        .stall(stall), .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr),
        .Zero(Zero), .Addr_Result(Addr_Result), .Read_data_1(Read_data_1),
        .commit(commit), .pc_misalign(pc_misalign), .retired_count(retired_count)
    );
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // model: phase 0 waiting for reset release, 1 fetching, 2 executing
    int          m_phase;
    logic [31:0] m_pc, m_instr, m_retired;
    logic        m_mis;
    function automatic logic [31:0] target();
        if (Jr) return Read_data_1 & ~32'd3;
        if (Jmp || Jal) return ((m_pc + 32'd4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
        if (Branch ? Zero : 1'b0) return Addr_Result * 4;
        if (nBranch ? !Zero : 1'b0) return Addr_Result * 4;
        return m_pc + 32'd4;
    endfunction
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_pc = 0; m_instr = 0; m_retired = 0; m_mis = 0;
        end else if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
            if (bus.imem_ack) begin m_instr = bus.imem_rdata; m_phase = 2; end
        end else if (!stall) begin
            if (Jr && Read_data_1[1:0] != 2'b00) m_mis = 1'b1;
            m_pc = target();
            m_retired = m_retired + 1;
            m_phase = 1;
        end
    end
    always @(negedge clock) if (!reset) begin
        chk("imem_req", 32'(bus.imem_req), 32'(m_phase == 1));
        chk("inst_valid", 32'(inst_valid), 32'(m_phase == 2));
        chk("commit", 32'(commit), 32'(m_phase == 2 && !stall));
        if (m_phase == 1) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[15:2]));
        chk("Instruction", Instruction, m_instr);
        chk("PC_plus_4", PC_plus_4, m_pc + 32'd4);
        chk("retired_count", retired_count, m_retired);
        chk("pc_misalign", 32'(pc_misalign), 32'(m_mis));
    end
    // called at posedge+2 while in FETCH; returns in EXEC at posedge+2
    task automatic fetch(input int waits, input logic [31:0] word, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            if (bus.imem_req && !inst_valid) req_cycles++;
            @(posedge clock); #2;
        end
        bus.imem_ack = 1'b1; bus.imem_rdata = word;
        @(negedge clock);
        if (bus.imem_req && !inst_valid) req_cycles++;
        @(posedge clock); #2;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'hBAD0_BAD0;
    endtask
    // called at posedge+2 in EXEC; returns in FETCH at posedge+2
    task automatic exec(input int stalls, input logic [4:0] ctl, input logic z,
                        input logic [31:0] ar, input logic [31:0] rd1,
                        output int valid_cycles, output int commits);
        {Branch, nBranch, Jmp, Jal, Jr} = ctl;
        Zero = z; Addr_Result = ar; Read_data_1 = rd1;
        valid_cycles = 0; commits = 0;
        for (int i = 0; i <= stalls; i++) begin
            stall = (i < stalls);
            @(negedge clock);
            valid_cycles += 32'(inst_valid);
            commits += 32'(commit);
            @(posedge clock); #2;
        end
        {Branch, nBranch, Jmp, Jal, Jr} = 5'b0;
        stall = 1'b0; Zero = 1'b0; Addr_Result = 32'h0; Read_data_1 = 32'h0;
    endtask
    localparam logic [4:0] NONE = 5'b00000, BEQ = 5'b10000, BNE = 5'b01000,
                           JMP = 5'b00100, JAL = 5'b00010, JR = 5'b00001;
    int rq, vc, cm;
    initial begin
        stall = 0; {Branch, nBranch, Jmp, Jal, Jr} = NONE; Zero = 0;
        Addr_Result = 0; Read_data_1 = 0; bus.imem_ack = 0; bus.imem_rdata = 0;
        repeat (2) @(posedge clock);
        #2;
        chk("reset_req", 32'(bus.imem_req), 32'd0);
        chk("reset_instr", Instruction, 32'd0);
        chk("reset_pc4", PC_plus_4, 32'd4);
        reset = 1'b0;
        @(posedge clock); #2;
        chk("first_addr", 32'(bus.imem_addr), 32'd0);
        fetch(0, 32'h2008_0005, rq);
        chk("first_instr", Instruction, 32'h2008_0005);
        chk("first_pc4", PC_plus_4, 32'd4);
        exec(0, NONE, 0, 0, 0, vc, cm);
        chk("first_commit", 32'(cm), 32'd1);
        chk("first_pc", 32'(bus.imem_addr), 32'd1);
        chk("first_retired", retired_count, 32'd1);
        fetch(3, 32'h1000_0003, rq);
        chk("delay_req_cycles", 32'(rq), 32'd4);
        exec(0, BEQ, 1, 32'h10, 0, vc, cm);
        chk("beq_taken", PC_plus_4, 32'h44);
        fetch(0, 32'h1000_0003, rq);
        exec(0, BEQ, 0, 32'h10, 0, vc, cm);
        chk("beq_not_taken", PC_plus_4, 32'h48);
        fetch(0, 32'h1400_0003, rq);
        exec(0, BNE, 0, 32'h30, 0, vc, cm);
        chk("bne_taken", PC_plus_4, 32'hC4);
        fetch(0, 32'h0000_0008, rq);
        exec(0, JR, 0, 0, 32'h100, vc, cm);
        chk("jr_aligned_pc", PC_plus_4, 32'h104);
        chk("jr_aligned_mis", 32'(pc_misalign), 32'd0);
        fetch(1, 32'h0800_0020, rq);
        exec(0, JMP, 0, 0, 0, vc, cm);
        chk("j_pc", PC_plus_4, 32'h84);
        fetch(0, 32'h0000_0008, rq);
        exec(0, JR, 0, 0, 32'h203, vc, cm);
        chk("jr_mis_pc", PC_plus_4, 32'h204);
        chk("jr_mis_flag", 32'(pc_misalign), 32'd1);
        fetch(2, 32'h0800_0040, rq);
        exec(2, JR | JMP, 0, 0, 32'h300, vc, cm);
        chk("stall_valid_cycles", 32'(vc), 32'd3);
        chk("stall_commits", 32'(cm), 32'd1);
        chk("jr_over_j", 32'(bus.imem_addr), 32'hC0);
        fetch(0, 32'h0000_0008, rq);
        exec(0, JR, 0, 0, 32'hFFFF_FFFC, vc, cm);
        chk("top_pc4_wrap", PC_plus_4, 32'h0);
        fetch(0, 32'h0000_0000, rq);
        exec(0, NONE, 0, 0, 0, vc, cm);
        chk("wrap_pc", 32'(bus.imem_addr), 32'd0);
        fetch(0, 32'h0C00_0010, rq);
        exec(0, JAL, 0, 0, 0, vc, cm);
        chk("jal_pc", PC_plus_4, 32'h44);
        chk("mis_sticky", 32'(pc_misalign), 32'd1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(bus.imem_req), 32'd0);
        chk("rst_mid_instr", Instruction, 32'd0);
        chk("rst_mid_pc", PC_plus_4, 32'd4);
        chk("rst_mid_mis", 32'(pc_misalign), 32'd0);
        chk("rst_mid_retired", retired_count, 32'd0);
        @(posedge clock); #2;
        reset = 1'b0; bus.imem_ack = 1'b0;
        @(posedge clock); #2;
        fetch(0, 32'h2008_0005, rq);
        exec(0, NONE, 0, 0, 0, vc, cm);
        chk("post_rst_pc", 32'(bus.imem_addr), 32'd1);
        chk("post_rst_retired", retired_count, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
